sigan_sequencer: RTL

Measurement sequencer for the signature analyzer. It sits between the front-panel controls and the capture datapath (gate controller, word generator and signature latch). It arms the datapath for each measurement window and accepts each latched 16-bit signature. It compares successive signatures to drive the unstable indicator, supports single-shot hold mode, and flags missing captures with a timeout.

---
 rtl/sigan_sequencer_if.sv | 25 ++
 rtl/sigan_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sigan_sequencer_if.sv
// Front-panel / capture-datapath signal bundle for the signature analyzer sequencer.
// The sequencer takes the slave view; the driver of controls and signatures takes master.
interface sigan_sequencer_if;
  logic        hold;
  logic        rearm;
  logic        gate;
  logic        sig_valid;
  logic [15:0] sig_word;
  logic        arm;
  logic [15:0] disp_word;
  logic        disp_valid;
  logic        unstable;
  logic        timeout;
  logic        gate_led;

  modport master (
    output hold, rearm, gate, sig_valid, sig_word,
    input  arm, disp_word, disp_valid, unstable, timeout, gate_led
  );

  modport slave (
    input  hold, rearm, gate, sig_valid, sig_word,
    output arm, disp_word, disp_valid, unstable, timeout, gate_led
  );
endinterface

// File: rtl/sigan_sequencer.sv
// Measurement sequencer: arms the capture datapath, accepts latched signatures,
// tracks stability, supports single-shot hold, flags missing captures, stretches the gate LED.
module sigan_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned STABLE_COUNT   = 2,
  parameter int unsigned LED_STRETCH    = 1024
) (
  input  logic               clk,
  input  logic               reset_l,
  sigan_sequencer_if.slave   bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned MW = $clog2(STABLE_COUNT + 1);
  localparam int unsigned LW = $clog2(LED_STRETCH + 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HELD} state_t;

  state_t        state_q, state_d;
  logic          arm_q, arm_d;
  logic [15:0]   disp_word_q, disp_word_d;
  logic          disp_valid_q, disp_valid_d;
  logic          unstable_q, unstable_d;
  logic          timeout_q, timeout_d;
  logic          prev_valid_q, prev_valid_d;
  logic [MW-1:0] match_q, match_d, match_inc;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [LW-1:0] led_cnt_q, led_cnt_d;
  logic          gate_led_q, gate_led_d;
  logic          window, accept, expire;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= IDLE;
      arm_q        <= 1'b0;
      disp_word_q  <= '0;
      disp_valid_q <= 1'b0;
      unstable_q   <= 1'b0;
      timeout_q    <= 1'b0;
      prev_valid_q <= 1'b0;
      match_q      <= '0;
      tcnt_q       <= '0;
      led_cnt_q    <= '0;
      gate_led_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      arm_q        <= arm_d;
      disp_word_q  <= disp_word_d;
      disp_valid_q <= disp_valid_d;
      unstable_q   <= unstable_d;
      timeout_q    <= timeout_d;
      prev_valid_q <= prev_valid_d;
      match_q      <= match_d;
      tcnt_q       <= tcnt_d;
      led_cnt_q    <= led_cnt_d;
      gate_led_q   <= gate_led_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    disp_word_d  = disp_word_q;
    disp_valid_d = disp_valid_q;
    unstable_d   = unstable_q;
    timeout_d    = timeout_q;
    prev_valid_d = prev_valid_q;
    match_d      = match_q;
    match_inc    = match_q;
    tcnt_d       = tcnt_q;
    led_cnt_d    = led_cnt_q;
    gate_led_d   = 1'b0;

    window = (state_q == ARMED) || (state_q == CAPTURE);
    accept = window && bus.sig_valid;
    // A signature arriving on the expiry cycle takes precedence over the timeout.
    expire = window && !bus.sig_valid && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    unique case (state_q)
      IDLE: begin
        state_d = ARMED;
        tcnt_d  = '0;
      end
      ARMED: begin
        if (accept)        state_d = bus.hold ? HELD : ARMED;
        else if (bus.gate) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (accept)         state_d = bus.hold ? HELD : ARMED;
        else if (!bus.gate) state_d = ARMED;
      end
      HELD: begin
        if (bus.rearm || !bus.hold) begin
          state_d = ARMED;
          tcnt_d  = '0;
        end
      end
    endcase

    if (window) begin
      if (accept || expire) tcnt_d = '0;
      else                  tcnt_d = tcnt_q + TW'(1);
    end

    if (accept) begin
      timeout_d = 1'b0;
      if (!prev_valid_q) begin
        disp_word_d  = bus.sig_word;
        disp_valid_d = 1'b1;
        unstable_d   = 1'b0;
        match_d      = '0;
        prev_valid_d = 1'b1;
      end else if (bus.sig_word != disp_word_q) begin
        unstable_d  = 1'b1;
        match_d     = '0;
        disp_word_d = bus.sig_word;
      end else begin
        match_inc = (match_q >= MW'(STABLE_COUNT)) ? match_q : match_q + MW'(1);
        match_d   = match_inc;
        if (match_inc >= MW'(STABLE_COUNT)) unstable_d = 1'b0;
      end
    end else if (expire) begin
      timeout_d    = 1'b1;
      disp_valid_d = 1'b0;
      prev_valid_d = 1'b0;
      unstable_d   = 1'b0;
    end

    if (bus.gate) begin
      led_cnt_d  = LW'(LED_STRETCH);
      gate_led_d = 1'b1;
    end else if (led_cnt_q != '0) begin
      led_cnt_d  = led_cnt_q - LW'(1);
      gate_led_d = 1'b1;
    end
  end

  assign arm_d = (state_d == ARMED) || (state_d == CAPTURE);

  assign bus.arm        = arm_q;
  assign bus.disp_word  = disp_word_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.unstable   = unstable_q;
  assign bus.timeout    = timeout_q;
  assign bus.gate_led   = gate_led_q;

endmodule
